// File: rtl/tlul_host_arb_pkg.sv
// Shared types and helpers for the TL-UL host arbiter.
//   NumHosts / MaxOutstanding : configuration of the arbiter slice
//   tl_h2d_t / tl_d2h_t       : TL-UL host->device and device->host bundles
//   host_idx_t                : index of an upstream host
//   rr_pick()                 : round-robin pick of the first requester at/after ptr
package tlul_host_arb_pkg;

    localparam int unsigned NumHosts       = 4;
    localparam int unsigned MaxOutstanding = 4;
    localparam int unsigned HostIdxW       = (NumHosts > 1) ? $clog2(NumHosts) : 1;
    localparam int unsigned CountW         = $clog2(MaxOutstanding + 1);

    typedef logic [HostIdxW-1:0] host_idx_t;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    // First set bit of req at or after ptr, wrapping modulo NumHosts.
    // Returns ptr when nothing requests; callers qualify with the request.
    function automatic host_idx_t rr_pick(input logic [NumHosts-1:0] req,
                                          input host_idx_t           ptr);
        host_idx_t pick;
        host_idx_t cand;
        logic      found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NumHosts; i++) begin
            cand = host_idx_t'((32'(ptr) + i) % NumHosts);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tlul_host_arb_idx_fifo.sv
// Synchronous FIFO of host indices recording the issue order of accepted
// requests, so in-order device responses can be routed back.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   push_i, wdata_i  : enqueue (ignored when full)
//   pop_i, rdata_o   : dequeue (ignored when empty), rdata_o is the head
//   full_o, empty_o  : occupancy flags
//   count_o          : number of stored entries
module tlul_host_arb_idx_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/tlul_host_arb.sv
// Round-robin arbiter sharing one TL-UL device port among NumHosts hosts.
// Requests are muxed onto the device port with zero latency; in-order
// responses are routed back using a FIFO of issuing host indices.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   tl_h_i/tl_h_o  : per-host request in / response + a_ready out
//   tl_d_o/tl_d_i  : shared device request out / response in
//   outstanding_o  : accepted but unanswered requests
//   idle_o         : no locked grant and nothing outstanding
//   rsp_err_o      : sticky flag, response seen with nothing outstanding
module tlul_host_arb
    import tlul_host_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  tl_h2d_t           tl_h_i [NumHosts],
    output tl_d2h_t           tl_h_o [NumHosts],
    output tl_h2d_t           tl_d_o,
    input  tl_d2h_t           tl_d_i,
    output logic [CountW-1:0] outstanding_o,
    output logic              idle_o,
    output logic              rsp_err_o
);

    logic [NumHosts-1:0] req_vec;
    host_idx_t           rr_ptr_q;
    host_idx_t           gnt_q;
    logic                lock_q;
    host_idx_t           gnt;
    host_idx_t           head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                accept;
    logic                pop;
    logic                err_q;

    always_comb begin
        req_vec = '0;
        for (int unsigned h = 0; h < NumHosts; h++) begin
            req_vec[h] = tl_h_i[h].a_valid;
        end
    end

    assign gnt = lock_q ? gnt_q : rr_pick(req_vec, rr_ptr_q);

    // Handshakes are suppressed during reset so nothing is accepted or
    // drained that the cleared FIFO could not account for.
    always_comb begin
        tl_d_o         = tl_h_i[gnt];
        tl_d_o.a_valid = tl_h_i[gnt].a_valid && !fifo_full && !rst_i;
        // With nothing outstanding, any response is stray: drain it.
        tl_d_o.d_ready = (fifo_empty ? tl_d_i.d_valid : tl_h_i[head].d_ready) && !rst_i;
    end

    assign accept = tl_d_o.a_valid && tl_d_i.a_ready;
    assign pop    = tl_d_i.d_valid && tl_d_o.d_ready && !fifo_empty;

    always_comb begin
        for (int unsigned h = 0; h < NumHosts; h++) begin
            tl_h_o[h]         = tl_d_i;
            tl_h_o[h].d_valid = 1'b0;
            tl_h_o[h].a_ready = 1'b0;
        end
        tl_h_o[gnt].a_ready = accept;
        if (!fifo_empty) begin
            tl_h_o[head].d_valid = tl_d_i.d_valid;
        end
    end

    tlul_host_arb_idx_fifo #(
        .Depth (MaxOutstanding),
        .Width (HostIdxW)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .wdata_i (gnt),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                lock_q   <= 1'b0;
                rr_ptr_q <= host_idx_t'((32'(gnt) + 1) % NumHosts);
            end else if (tl_d_o.a_valid) begin
                lock_q <= 1'b1;
                gnt_q  <= gnt;
            end
            if (tl_d_i.d_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rsp_err_o = err_q;
    assign idle_o    = !lock_q && (outstanding_o == '0);

endmodule

// File: tb/tb_tlul_host_arb.sv
// Self-checking bench for tlul_host_arb (4 hosts, 4 outstanding).
module tb_tlul_host_arb;
    import tlul_host_arb_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    tl_h2d_t           h_in  [NumHosts];
    tl_d2h_t           h_out [NumHosts];
    tl_h2d_t           d_out;
    tl_d2h_t           d_in;
    logic [CountW-1:0] outst;
    logic              idle;
    logic              err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlul_host_arb dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .tl_h_i        (h_in),
        .tl_h_o        (h_out),
        .tl_d_o        (d_out),
        .tl_d_i        (d_in),
        .outstanding_o (outst),
        .idle_o        (idle),
        .rsp_err_o     (err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] aready_vec();
        logic [3:0] r;
        for (int h = 0; h < 4; h++) r[h] = h_out[h].a_ready;
        return r;
    endfunction

    function automatic logic [3:0] dvalid_vec();
        logic [3:0] r;
        for (int h = 0; h < 4; h++) r[h] = h_out[h].d_valid;
        return r;
    endfunction

    // Fixed payload per host: a_source = host*16, a_data = A5A50000 + host.
    task automatic drive(input logic [3:0] hv, input logic ar, input logic dv, input logic [3:0] hdr);
        for (int h = 0; h < 4; h++) begin
            h_in[h]          = '0;
            h_in[h].a_valid  = hv[h];
            h_in[h].a_source = 8'(h * 16);
            h_in[h].a_data   = 32'hA5A5_0000 + 32'(h);
            h_in[h].d_ready  = hdr[h];
        end
        d_in         = '0;
        d_in.a_ready = ar;
        d_in.d_valid = dv;
        d_in.d_data  = 32'hD000_0000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'b0000, 1'b0, 1'b0, 4'b0000);
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  hv;
        logic        ar;
        logic        dv;
        logic [3:0]  hdr;
        logic        e_av;
        int unsigned e_gnt;
        logic [3:0]  e_ar;
        logic [3:0]  e_dv;
        logic        e_dr;
        int unsigned e_out;
        logic        e_idle;
    } vec_t;

    vec_t vt [16];

    // Random-phase state
    logic        pend  [4];
    logic [7:0]  psrc  [4];
    logic [31:0] pdata [4];
    int          seqn  [4];
    typedef struct { logic [7:0] src; logic [31:0] data; } rsp_t;
    rsp_t        devq [$];
    logic        dact;
    int          mq   [$];
    int          m_rr;
    logic        m_lock;
    int          m_lh;

    initial begin
        // --- reset state ---------------------------------------------------
        drive(4'b0000, 1'b1, 1'b0, 4'b1111);
        #2;
        chk("rst_idle", idle, 1'b1);
        chk("rst_outst", outst, 0);
        chk("rst_err", err, 1'b0);
        chk("rst_aready", aready_vec(), 4'b0000);
        chk("rst_dvalid", dvalid_vec(), 4'b0000);
        chk("rst_dev_dready", d_out.d_ready, 1'b0);
        do_reset();
        drive(4'b0000, 1'b1, 1'b0, 4'b1111);
        tick();
        chk("idle_idle", idle, 1'b1);
        chk("idle_outst", outst, 0);
        chk("idle_aready", aready_vec(), 4'b0000);
        chk("idle_dvalid", dvalid_vec(), 4'b0000);
        chk("idle_dev_avalid", d_out.a_valid, 1'b0);

        // --- table: round-robin order, in-order routing, lock, push+pop ----
        //          hv       ar    dv    hdr      av    g  e_ar     e_dv     dr  out idle
        vt[0]  = '{4'b1101, 1'b1, 1'b0, 4'b1111, 1'b1, 0, 4'b0001, 4'b0000, 1'b0, 0, 1'b1};
        vt[1]  = '{4'b1100, 1'b1, 1'b0, 4'b1111, 1'b1, 2, 4'b0100, 4'b0000, 1'b1, 1, 1'b0};
        vt[2]  = '{4'b1000, 1'b1, 1'b0, 4'b1111, 1'b1, 3, 4'b1000, 4'b0000, 1'b1, 2, 1'b0};
        vt[3]  = '{4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 0, 4'b0000, 4'b0001, 1'b1, 3, 1'b0};
        vt[4]  = '{4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 0, 4'b0000, 4'b0100, 1'b1, 2, 1'b0};
        vt[5]  = '{4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 0, 4'b0000, 4'b1000, 1'b1, 1, 1'b0};
        vt[6]  = '{4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0, 0, 4'b0000, 4'b0000, 1'b0, 0, 1'b1};
        vt[7]  = '{4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1, 0, 4'b0001, 4'b0000, 1'b0, 0, 1'b1};
        vt[8]  = '{4'b1110, 1'b1, 1'b0, 4'b1111, 1'b1, 1, 4'b0010, 4'b0000, 1'b1, 1, 1'b0};
        vt[9]  = '{4'b1100, 1'b0, 1'b1, 4'b1111, 1'b1, 2, 4'b0000, 4'b0001, 1'b1, 2, 1'b0};
        vt[10] = '{4'b1100, 1'b1, 1'b1, 4'b1111, 1'b1, 2, 4'b0100, 4'b0010, 1'b1, 1, 1'b0};
        vt[11] = '{4'b1000, 1'b0, 1'b0, 4'b1111, 1'b1, 3, 4'b0000, 4'b0000, 1'b1, 1, 1'b0};
        vt[12] = '{4'b1000, 1'b1, 1'b1, 4'b1011, 1'b1, 3, 4'b1000, 4'b0100, 1'b0, 1, 1'b0};
        vt[13] = '{4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 0, 4'b0000, 4'b0100, 1'b1, 2, 1'b0};
        vt[14] = '{4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 0, 4'b0000, 4'b1000, 1'b1, 1, 1'b0};
        vt[15] = '{4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0, 0, 4'b0000, 4'b0000, 1'b0, 0, 1'b1};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(vt[i].hv, vt[i].ar, vt[i].dv, vt[i].hdr);
            #2;
            chk($sformatf("tbl%0d_avalid", i), d_out.a_valid, vt[i].e_av);
            if (vt[i].e_av) chk($sformatf("tbl%0d_gnt", i), d_out.a_source[7:4], vt[i].e_gnt);
            chk($sformatf("tbl%0d_aready", i), aready_vec(), vt[i].e_ar);
            chk($sformatf("tbl%0d_dvalid", i), dvalid_vec(), vt[i].e_dv);
            chk($sformatf("tbl%0d_dready", i), d_out.d_ready, vt[i].e_dr);
            chk($sformatf("tbl%0d_outst", i), outst, vt[i].e_out);
            chk($sformatf("tbl%0d_idle", i), idle, vt[i].e_idle);
            tick();
        end

        // --- grant lock under device back-pressure -------------------------
        do_reset();
        drive(4'b0010, 1'b0, 1'b0, 4'b1111);
        #2;
        chk("lock_first_gnt", d_out.a_source, 8'h10);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(4'b1011, 1'b0, 1'b0, 4'b1111);
            #2;
            chk("lock_hold_src", d_out.a_source, 8'h10);
            chk("lock_hold_data", d_out.a_data, 32'hA5A5_0001);
            chk("lock_hold_aready", aready_vec(), 4'b0000);
            tick();
        end
        drive(4'b1011, 1'b1, 1'b0, 4'b1111);
        #2;
        chk("lock_release_aready", aready_vec(), 4'b0010);
        tick();
        drive(4'b1001, 1'b1, 1'b0, 4'b1111);
        #2;
        chk("lock_next_src", d_out.a_source, 8'h30);
        chk("lock_next_aready", aready_vec(), 4'b1000);
        tick();
        drive(4'b0001, 1'b1, 1'b0, 4'b1111);
        #2;
        chk("lock_wrap_aready", aready_vec(), 4'b0001);
        tick();

        // --- FIFO full back-pressure ---------------------------------------
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(4'b1111, 1'b1, 1'b0, 4'b1111);
            #2;
            chk("full_outst", outst, (k < 4) ? k : 4);
            chk("full_aready", aready_vec(), (k < 4) ? 4'(1 << k) : 4'b0000);
            chk("full_avalid", d_out.a_valid, k < 4);
            tick();
        end
        drive(4'b1111, 1'b1, 1'b1, 4'b1111);
        #2;
        chk("full_pop_dvalid", dvalid_vec(), 4'b0001);
        chk("full_pop_no_pass", d_out.a_valid, 1'b0);
        chk("full_pop_aready", aready_vec(), 4'b0000);
        tick();
        drive(4'b1111, 1'b1, 1'b0, 4'b1111);
        #2;
        chk("full_refill_outst", outst, 3);
        chk("full_refill_aready", aready_vec(), 4'b0001);
        tick();
        chk("full_refill_after", outst, 4);

        // --- simultaneous push and pop at two outstanding ------------------
        do_reset();
        drive(4'b0011, 1'b1, 1'b0, 4'b1111);
        tick();
        drive(4'b0010, 1'b1, 1'b0, 4'b1111);
        tick();
        drive(4'b0100, 1'b1, 1'b1, 4'b1111);
        d_in.d_data = 32'h1234_5678;
        #2;
        chk("pp_outst_before", outst, 2);
        chk("pp_aready", aready_vec(), 4'b0100);
        chk("pp_dvalid", dvalid_vec(), 4'b0001);
        chk("pp_ddata", h_out[0].d_data, 32'h1234_5678);
        tick();
        drive(4'b0000, 1'b0, 1'b1, 4'b1111);
        #2;
        chk("pp_outst_after", outst, 2);
        chk("pp_next_head", dvalid_vec(), 4'b0010);
        tick();

        // --- stray response and asynchronous reset -------------------------
        do_reset();
        drive(4'b0000, 1'b0, 1'b1, 4'b0000);
        #2;
        chk("stray_dready", d_out.d_ready, 1'b1);
        chk("stray_dvalid", dvalid_vec(), 4'b0000);
        tick();
        drive(4'b0000, 1'b0, 1'b0, 4'b1111);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("stray_err_sticky", err, 1'b1);
            tick();
        end
        drive(4'b1111, 1'b1, 1'b0, 4'b1111);
        tick();
        tick();
        #2;
        chk("burst_outst", outst, 2);
        rst = 1'b1;
        #1;
        chk("async_rst_outst", outst, 0);
        chk("async_rst_err", err, 1'b0);
        chk("async_rst_idle", idle, 1'b1);
        chk("async_rst_avalid", d_out.a_valid, 1'b0);
        chk("async_rst_aready", aready_vec(), 4'b0000);
        tick();
        drive(4'b0000, 1'b0, 1'b0, 4'b1111);
        rst = 1'b0;
        tick();
        chk("post_rst_idle", idle, 1'b1);

        // --- randomized traffic vs. transaction-level model ----------------
        do_reset();
        for (int h = 0; h < 4; h++) begin
            pend[h] = 1'b0;
            seqn[h] = 0;
            psrc[h] = '0;
            pdata[h] = '0;
        end
        devq.delete();
        mq.delete();
        dact   = 1'b0;
        m_rr   = 0;
        m_lock = 1'b0;
        m_lh   = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int          gv;
            logic        eav;
            logic        acc;
            logic        popd;
            logic [3:0]  ear;
            logic [3:0]  edv;
            for (int h = 0; h < 4; h++) begin
                if (!pend[h] && $urandom_range(0, 2) == 0) begin
                    pend[h]  = 1'b1;
                    seqn[h]  = seqn[h] + 1;
                    psrc[h]  = {4'(h), 4'(seqn[h])};
                    pdata[h] = $urandom;
                end
                h_in[h]           = '0;
                h_in[h].a_valid   = pend[h];
                h_in[h].a_source  = psrc[h];
                h_in[h].a_data    = pdata[h];
                h_in[h].a_address = {pdata[h][29:0], 2'b00};
                h_in[h].d_ready   = ($urandom_range(0, 3) != 0);
            end
            d_in         = '0;
            d_in.a_ready = ($urandom_range(0, 3) != 0);
            if (!dact && devq.size() > 0 && $urandom_range(0, 1) == 1) dact = 1'b1;
            if (dact) begin
                d_in.d_valid  = 1'b1;
                d_in.d_source = devq[0].src;
                d_in.d_data   = devq[0].data;
            end
            #2;
            gv = -1;
            if (m_lock) gv = m_lh;
            else begin
                for (int k = 0; k < 4; k++) begin
                    if (gv < 0 && pend[(m_rr + k) % 4]) gv = (m_rr + k) % 4;
                end
            end
            eav = (gv >= 0) && (mq.size() < MaxOutstanding);
            acc = eav && d_in.a_ready;
            ear = acc ? 4'(1 << gv) : 4'b0000;
            edv = (dact && mq.size() > 0) ? 4'(1 << mq[0]) : 4'b0000;
            chk("rnd_avalid", d_out.a_valid, eav);
            if (eav) begin
                chk("rnd_asrc", d_out.a_source, psrc[gv]);
                chk("rnd_adata", d_out.a_data, pdata[gv]);
            end
            chk("rnd_aready", aready_vec(), ear);
            chk("rnd_dvalid", dvalid_vec(), edv);
            if (mq.size() > 0) begin
                chk("rnd_dready", d_out.d_ready, h_in[mq[0]].d_ready);
                if (dact) chk("rnd_dsrc", h_out[mq[0]].d_source, devq[0].src);
            end
            chk("rnd_outst", outst, mq.size());
            chk("rnd_idle", idle, !m_lock && mq.size() == 0);
            chk("rnd_err", err, 1'b0);
            popd = dact && mq.size() > 0 && h_in[mq[0]].d_ready;
            if (popd) begin
                void'(mq.pop_front());
                void'(devq.pop_front());
                dact = 1'b0;
            end
            if (acc) begin
                mq.push_back(gv);
                devq.push_back('{psrc[gv], pdata[gv]});
                pend[gv] = 1'b0;
                m_lock   = 1'b0;
                m_rr     = (gv + 1) % 4;
            end else if (eav) begin
                m_lock = 1'b1;
                m_lh   = gv;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
